// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: multi-cycle data-memory handshake FSM that freezes the pipeline,
// merged with load-use / branch-flush requests into per-stage stall and flush strobes.
module mem_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        load_use_i,
  input  logic        branch_flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] rdata_o,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        mem_stall_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic acc, last;
  assign acc = MemRead_i | MemWrite_i;
  assign last = cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // RELEASE always returns to IDLE so the finished access cannot re-trigger
  always_comb
    state_nx = state == IDLE ? (acc ? ACCESS : IDLE) :
               state == ACCESS ? (mem_ack_i || last ? RELEASE : ACCESS) : IDLE;
  always_comb begin
    mem_req_o = state == ACCESS;
    mem_stall_o = state == ACCESS || (state == IDLE && acc);
    pc_stall_o = mem_stall_o | load_use_i;
    ifid_stall_o = mem_stall_o | load_use_i;
    idex_flush_o = (load_use_i | branch_flush_i) & ~mem_stall_o;
    ifid_flush_o = branch_flush_i & ~mem_stall_o;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      mem_we_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else if (state == IDLE && acc) begin
      cnt <= '0;
      mem_we_o <= MemWrite_i;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
      if (mem_ack_i) begin
        if (!mem_we_o) rdata_o <= mem_rdata_i;
      end else if (last) begin
        err_o <= 1'b1;
        rdata_o <= '0;
      end
    end
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: randomized transactions with a scoreboard of expected access outcomes.
module tb_mem_stall_ctrl;
  localparam int TO = 4;
  logic clk = 0, rst_i = 0;
  logic MemRead_i = 0, MemWrite_i = 0, mem_ack_i = 0, load_use_i = 0, branch_flush_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic mem_req_o, mem_we_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o, mem_stall_o, err_o;
  logic [31:0] rdata_o;
  always #5 clk = ~clk;

  mem_stall_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .load_use_i(load_use_i),
    .branch_flush_i(branch_flush_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .rdata_o(rdata_o), .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .mem_stall_o(mem_stall_o),
    .err_o(err_o)
  );

  typedef struct {logic we; int n; logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic exp_stall = 0, exp_req = 0, mon_en = 0, haz_all = 0;
  logic [31:0] m_rdata = 0;
  logic m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: k is the ACCESS cycle carrying the ack; k > TO means no ack at all.
  task automatic txn(input logic we, input int k, input logic [31:0] d);
    int n;
    exp_t e;
    n = (k <= TO) ? k : TO;
    if (k > TO) begin m_err = 1; m_rdata = 0; end
    else if (!we) m_rdata = d;
    e.we = we; e.n = n; e.rdata = m_rdata; e.err = m_err;
    sb.push_back(e);
    MemRead_i = !we; MemWrite_i = we; mem_ack_i = $urandom_range(0, 1);
    exp_stall = 1; exp_req = 0;
    step();
    for (int i = 1; i <= n; i++) begin
      mem_ack_i = (i == k);
      mem_rdata_i = (i == k) ? d : $urandom;
      exp_stall = 1; exp_req = 1;
      step();
    end
    mem_ack_i = $urandom_range(0, 1); mem_rdata_i = $urandom;
    exp_stall = 0; exp_req = 0;
    step();
  endtask

  task automatic idle(input int g);
    for (int i = 0; i < g; i++) begin
      MemRead_i = 0; MemWrite_i = 0; mem_ack_i = $urandom_range(0, 1); mem_rdata_i = $urandom;
      exp_stall = 0; exp_req = 0;
      step();
    end
  endtask

  initial forever begin
    step();
    load_use_i = haz_all | ($urandom_range(0, 3) == 0);
    branch_flush_i = haz_all | ($urandom_range(0, 3) == 0);
  end

  logic prev_req = 0, seen = 0, we_start = 0, we_bad = 0;
  int req_len = 0, stall_len = 0, low_len = 0;
  always @(negedge clk) if (mon_en) begin
    chk("mem_stall", mem_stall_o, exp_stall);
    chk("mem_req", mem_req_o, exp_req);
    chk("pc_stall", pc_stall_o, exp_stall | load_use_i);
    chk("ifid_stall", ifid_stall_o, exp_stall | load_use_i);
    chk("idex_flush", idex_flush_o, (load_use_i | branch_flush_i) & ~exp_stall);
    chk("ifid_flush", ifid_flush_o, branch_flush_i & ~exp_stall);
    if (mem_req_o && !prev_req) begin
      if (seen) chk("req_gap_ge2", low_len >= 2, 1);
      seen = 1; we_start = mem_we_o; req_len = 0; we_bad = 0;
    end
    if (mem_req_o) begin
      req_len++;
      if (mem_we_o !== we_start) we_bad = 1;
    end
    if (!mem_req_o && prev_req) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_release: got req end expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("req_len", req_len, e.n);
        chk("stall_len", stall_len, e.n + 1);
        chk("mem_we", we_start, e.we);
        chk("we_stable", we_bad, 0);
        chk("rdata", rdata_o, e.rdata);
        chk("err", err_o, e.err);
      end
    end
    stall_len = mem_stall_o ? stall_len + 1 : 0;
    low_len = mem_req_o ? 0 : low_len + 1;
    prev_req = mem_req_o;
  end

  initial begin
    rst_i = 1;
    #12;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    step();
    rst_i = 0;
    step();
    mon_en = 1;
    txn(0, 3, 32'hDEADBEEF);
    idle(1);
    txn(1, 1, 32'h12345678);
    idle(2);
    txn(0, TO + 1, 32'hAAAA5555);
    idle(1);
    haz_all = 1;
    txn(0, 2, 32'hCAFEF00D);
    haz_all = 0;
    idle(1);
    txn(0, 1, 32'h11111111);
    txn(0, 1, 32'h22222222);
    for (int t = 0; t < 40; t++) begin
      txn($urandom_range(0, 1), $urandom_range(1, TO + 1), $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    mon_en = 0;
    MemRead_i = 1;
    step();
    step();
    step();
    MemRead_i = 0;
    rst_i = 1;
    #1;
    chk("midrst_req", mem_req_o, 0);
    chk("midrst_rdata", rdata_o, 0);
    chk("midrst_err", err_o, 0);
    step();
    rst_i = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h87654321;
    step();
    mem_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_req", mem_req_o, 0);
      chk("late_ack_stall", mem_stall_o, 0);
      chk("late_ack_rdata", rdata_o, 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
